// File: rtl/std_fifo_core.sv
// Single-clock FIFO with registered read port, occupancy count and watermark flags.
// Define STD_FIFO_CHECK_EN to compile simulation-only overflow/underflow checks.
module std_fifo_core #(
    parameter int WIDTH              = 32,
    parameter int DEPTH              = 32,
    parameter int ALMOST_FULL_COUNT  = 4,
    parameter int ALMOST_EMPTY_COUNT = 4
) (
    input  logic                       rst,
    input  logic                       clk,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           q,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_empty,
    output logic                       almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             push_eff;
    logic             pop_eff;

    // A push on a full FIFO is allowed only when a pop frees the head slot in the same cycle.
    assign push_eff = push && (!full || pop);
    assign pop_eff  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        q_d      = q_q;
        count_d  = count_q + CW'(push_eff) - CW'(pop_eff);
        if (push_eff) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            q_d      = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            q_q      <= q_d;
        end
    end

    // Storage is deliberately not reset; the read of a full-FIFO head precedes its overwrite.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= d;
        end
    end

    assign q            = q_q;
    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_empty = (int'(count_q) <= ALMOST_EMPTY_COUNT);
    assign almost_full  = (int'(count_q) >= DEPTH - ALMOST_FULL_COUNT);

`ifdef STD_FIFO_CHECK_EN
    always @(posedge clk) begin
        if (rst) begin
            if (push && full && !pop)
                $error("%0t %m: push while full ignored", $time);
            if (pop && empty)
                $error("%0t %m: pop while empty ignored", $time);
            if (int'(count_d) > DEPTH)
                $fatal(1, "%0t %m: occupancy exceeds DEPTH", $time);
        end
    end
`else
    // Illegal operations are silently ignored in this build.
`endif

endmodule

// File: tb/tb_std_fifo_core.sv
// Directed self-checking bench for std_fifo_core (WIDTH=64, DEPTH=32, almost-full at 24).
module tb_std_fifo_core;

    localparam int WIDTH = 64;
    localparam int DEPTH = 32;
    localparam int AFC   = 8;
    localparam int AEC   = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             rst;
    logic             clk;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             almost_empty;
    logic             almost_full;

    int n_tests;
    int n_fail;

    std_fifo_core #(
        .WIDTH(WIDTH), .DEPTH(DEPTH),
        .ALMOST_FULL_COUNT(AFC), .ALMOST_EMPTY_COUNT(AEC)
    ) dut (
        .rst(rst), .clk(clk), .push(push), .pop(pop), .d(d), .q(q),
        .full(full), .empty(empty), .count(count),
        .almost_empty(almost_empty), .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic [63:0] d;
        logic [63:0] exp_q;
        int          exp_count;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_ae;
        logic        exp_af;
        string       name;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [63:0] eq, input int ec,
                             input logic ee, input logic ef, input logic eae, input logic eaf);
        check({name, ".q"},     q, eq);
        check({name, ".count"}, 64'(count), 64'(ec));
        check({name, ".empty"}, 64'(empty), 64'(ee));
        check({name, ".full"},  64'(full), 64'(ef));
        check({name, ".ae"},    64'(almost_empty), 64'(eae));
        check({name, ".af"},    64'(almost_full), 64'(eaf));
    endtask

    task automatic step(input logic pu, input logic po, input logic [63:0] dd);
        push = pu;
        pop  = po;
        d    = dd;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        push = 1'b0;
        pop  = 1'b0;
        d    = '0;
        rst  = 1'b0;

        //          push  pop   d       q       cnt empty full ae   af
        vecs[0]  = '{1'b1, 1'b0, 64'h1,  64'h0,  1, 1'b0, 1'b0, 1'b1, 1'b0, "push1"};
        vecs[1]  = '{1'b1, 1'b0, 64'h2,  64'h0,  2, 1'b0, 1'b0, 1'b1, 1'b0, "push2"};
        vecs[2]  = '{1'b1, 1'b0, 64'h3,  64'h0,  3, 1'b0, 1'b0, 1'b1, 1'b0, "push3"};
        vecs[3]  = '{1'b1, 1'b0, 64'h4,  64'h0,  4, 1'b0, 1'b0, 1'b1, 1'b0, "push4"};
        vecs[4]  = '{1'b1, 1'b0, 64'h5,  64'h0,  5, 1'b0, 1'b0, 1'b0, 1'b0, "push5"};
        vecs[5]  = '{1'b0, 1'b1, 64'h0,  64'h1,  4, 1'b0, 1'b0, 1'b1, 1'b0, "pop1"};
        vecs[6]  = '{1'b0, 1'b1, 64'h0,  64'h2,  3, 1'b0, 1'b0, 1'b1, 1'b0, "pop2"};
        vecs[7]  = '{1'b0, 1'b1, 64'h0,  64'h3,  2, 1'b0, 1'b0, 1'b1, 1'b0, "pop3"};
        vecs[8]  = '{1'b0, 1'b1, 64'h0,  64'h4,  1, 1'b0, 1'b0, 1'b1, 1'b0, "pop4"};
        vecs[9]  = '{1'b0, 1'b1, 64'h0,  64'h5,  0, 1'b1, 1'b0, 1'b1, 1'b0, "pop5"};
        vecs[10] = '{1'b0, 1'b1, 64'h0,  64'h5,  0, 1'b1, 1'b0, 1'b1, 1'b0, "pop_empty"};
        vecs[11] = '{1'b1, 1'b1, 64'hAB, 64'h5,  1, 1'b0, 1'b0, 1'b1, 1'b0, "pushpop_empty"};
        vecs[12] = '{1'b1, 1'b1, 64'hCD, 64'hAB, 1, 1'b0, 1'b0, 1'b1, 1'b0, "pushpop_one"};
        vecs[13] = '{1'b0, 1'b1, 64'h0,  64'hCD, 0, 1'b1, 1'b0, 1'b1, 1'b0, "pop_cd"};
        vecs[14] = '{1'b1, 1'b0, 64'hAB, 64'hCD, 1, 1'b0, 1'b0, 1'b1, 1'b0, "push_ab"};
        vecs[15] = '{1'b0, 1'b1, 64'h0,  64'hAB, 0, 1'b1, 1'b0, 1'b1, 1'b0, "pop_ab"};
        vecs[16] = '{1'b0, 1'b1, 64'h0,  64'hAB, 0, 1'b1, 1'b0, 1'b1, 1'b0, "underflow1"};
        vecs[17] = '{1'b0, 1'b1, 64'h0,  64'hAB, 0, 1'b1, 1'b0, 1'b1, 1'b0, "underflow2"};
        vecs[18] = '{1'b0, 1'b1, 64'h0,  64'hAB, 0, 1'b1, 1'b0, 1'b1, 1'b0, "underflow3"};

        // Reset then idle
        do_reset();
        check_all("reset", 64'h0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 64'h0);
        check_all("idle", 64'h0, 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Ordering, empty push+pop and underflow vectors
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].d);
            check_all(vecs[i].name, vecs[i].exp_q, vecs[i].exp_count, vecs[i].exp_empty,
                      vecs[i].exp_full, vecs[i].exp_ae, vecs[i].exp_af);
        end

        // Fill 0..32; word 32 is dropped
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            int ec;
            step(1'b1, 1'b0, 64'(i));
            ec = (i + 1 > DEPTH) ? DEPTH : i + 1;
            check("fill.count", 64'(count), 64'(ec));
            check("fill.af",    64'(almost_full), 64'(ec >= DEPTH - AFC));
            check("fill.full",  64'(full), 64'(ec == DEPTH));
            check("fill.ae",    64'(almost_empty), 64'(ec <= AEC));
        end

        // Push+pop while full: old head comes out, 100 goes in at the tail
        step(1'b1, 1'b1, 64'd100);
        check_all("full_pushpop", 64'h0, DEPTH, 1'b0, 1'b1, 1'b0, 1'b1);

        for (int i = 1; i <= DEPTH; i++) begin
            logic [63:0] eq;
            eq = (i == DEPTH) ? 64'd100 : 64'(i);
            step(1'b0, 1'b1, 64'h0);
            check("drain.q", q, eq);
            check("drain.count", 64'(count), 64'(DEPTH - i));
        end
        check("drain.empty", 64'(empty), 64'h1);

        // Async reset between edges with count=10
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 64'(i + 16'h200));
        step(1'b0, 1'b1, 64'h0);
        step(1'b1, 1'b0, 64'h20A);
        check("pre_reset.count", 64'(count), 64'd10);
        check("pre_reset.q", q, 64'h200);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_reset", 64'h0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        #3;
        rst = 1'b1;
        step(1'b1, 1'b0, 64'h77);
        step(1'b0, 1'b1, 64'h0);
        check_all("post_reset", 64'h77, 0, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
